// File: rtl/iob_eth_rx_gen_pkg.sv
// Shared constants, state type and CRC helpers for the MII receive-side frame generator.
package iob_eth_rx_gen_pkg;

  localparam logic [3:0]  PRE_NIB      = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
  localparam int unsigned HDR_LEN      = 14;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_FCS,
    ST_IFG
  } state_t;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
    end
    return c;
  endfunction

  // FCS nibble idx (0 = first on the wire): complemented register, low bits first.
  function automatic logic [3:0] fcs_nibble(input logic [31:0] crc, input logic [2:0] idx);
    logic [31:0] f;
    f = ~crc;
    return f[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/iob_eth_crc.sv
// Byte-wide reflected CRC-32 engine (802.3 polynomial).
module iob_eth_crc
  import iob_eth_rx_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic        data_en,
  output logic [31:0] crc_out
);

  logic [31:0] r_crc;

  // Re-seed while start is held, otherwise fold in one byte per enable.
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (start) begin
      r_crc <= CRC_INIT;
    end else if (data_en) begin
      r_crc <= crc32_byte(r_crc, data_in);
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/iob_eth_rx_gen.sv
// PHY-side MII frame source: preamble, SFD, buffered frame bytes, FCS, then inter-frame gap.
module iob_eth_rx_gen
  import iob_eth_rx_gen_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIB = 15,
  parameter int unsigned IFG_CYC      = 24,
  parameter int unsigned MAX_PAYLOAD  = 1500
) (
  input  logic        RX_CLK,
  input  logic        rx_rst,
  input  logic        send,
  input  logic [10:0] nbytes,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        RX_DV,
  output logic [3:0]  RX_DATA
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_len;
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_hi;
  logic [7:0]         r_byte;
  logic               r_crc_en;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_dv;
  logic [3:0]         r_data;

  logic [31:0]        w_crc;
  logic               w_crc_start;
  logic [ADDR_W-1:0]  w_len_m1;
  logic [ADDR_W-1:0]  w_next_idx;
  logic               w_last;

  assign w_crc_start = (r_state == ST_PRE);
  assign w_len_m1    = r_len - 11'd1;
  assign w_next_idx  = r_idx + 11'd1;
  assign w_last      = (r_idx == w_len_m1);

  iob_eth_crc u_crc (
    .clk     (RX_CLK),
    .rst     (rx_rst),
    .start   (w_crc_start),
    .data_in (r_byte),
    .data_en (r_crc_en),
    .crc_out (w_crc)
  );

  // Frame sequencer. The read address runs one byte ahead of the byte on the wire so the
  // synchronous buffer has a full cycle before the byte latch samples it. The IFG state
  // covers IFG_CYC-1 idle cycles; the following IDLE cycle is the last one of the gap.
  always_ff @(posedge RX_CLK, posedge rx_rst) begin
    if (rx_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_hi      <= 1'b0;
      r_byte    <= '0;
      r_crc_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_dv      <= 1'b0;
      r_data    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_crc_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (send) begin
            if (nbytes > ADDR_W'(MAX_PAYLOAD)) begin
              r_err <= 1'b1;
            end else begin
              r_state   <= ST_PRE;
              r_busy    <= 1'b1;
              r_len     <= ADDR_W'(HDR_LEN) + nbytes;
              r_idx     <= '0;
              r_rd_addr <= '0;
              r_dv      <= 1'b1;
              r_data    <= PRE_NIB;
              r_cnt     <= CNT_W'(1);
            end
          end
        end
        ST_PRE: begin
          if (r_cnt == CNT_W'(PREAMBLE_NIB)) begin
            r_state <= ST_SFD;
            r_data  <= SFD_NIB;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_data <= PRE_NIB;
          end
        end
        ST_SFD: begin
          r_state   <= ST_DATA;
          r_hi      <= 1'b0;
          r_byte    <= rd_data;
          r_data    <= rd_data[3:0];
          r_crc_en  <= 1'b1;
          r_rd_addr <= 11'd1;
        end
        ST_DATA: begin
          if (!r_hi) begin
            r_hi   <= 1'b1;
            r_data <= r_byte[7:4];
          end else if (w_last) begin
            r_state <= ST_FCS;
            r_data  <= fcs_nibble(w_crc, 3'd0);
            r_cnt   <= CNT_W'(1);
          end else begin
            r_hi     <= 1'b0;
            r_idx    <= w_next_idx;
            r_byte   <= rd_data;
            r_data   <= rd_data[3:0];
            r_crc_en <= 1'b1;
            if (w_next_idx != w_len_m1) begin
              r_rd_addr <= w_next_idx + 11'd1;
            end
          end
        end
        ST_FCS: begin
          if (r_cnt == CNT_W'(8)) begin
            r_state <= ST_IFG;
            r_dv    <= 1'b0;
            r_data  <= '0;
            r_cnt   <= CNT_W'(1);
            r_done  <= (IFG_CYC == 2);
          end else begin
            r_data <= fcs_nibble(w_crc, r_cnt[2:0]);
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        ST_IFG: begin
          if (r_cnt >= CNT_W'(IFG_CYC - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(IFG_CYC - 2));
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign rd_addr = r_rd_addr;
  assign RX_DV   = r_dv;
  assign RX_DATA = r_data;

endmodule

// File: tb/tb_iob_eth_rx_gen.sv
// Directed bench for iob_eth_rx_gen: frame content, FCS, gap timing, reject/ignore, reset abort.
module tb_iob_eth_rx_gen;
  import iob_eth_rx_gen_pkg::*;

  logic        RX_CLK = 1'b0;
  logic        rx_rst;
  logic        send;
  logic [10:0] nbytes;
  logic        busy, done, err, RX_DV;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic [3:0]  RX_DATA;

  logic        u_start, u_en;
  logic [7:0]  u_data;
  logic [31:0] u_crc;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:2047];
  logic [3:0] cur_q[$];
  logic [3:0] last_q[$];
  logic [3:0] exp_q[$];
  int  frames = 0;
  int  last_res = 0;
  int  done_cnt = 0;
  int  low_run = 0;
  int  last_gap = -1;
  int  addr_viol = 0;
  int  cur_len = 0;
  logic prev_dv = 1'b0;

  always #5 RX_CLK = ~RX_CLK;

  iob_eth_rx_gen dut (
    .RX_CLK  (RX_CLK),
    .rx_rst  (rx_rst),
    .send    (send),
    .nbytes  (nbytes),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .RX_DV   (RX_DV),
    .RX_DATA (RX_DATA)
  );

  iob_eth_crc u_crc_unit (
    .clk     (RX_CLK),
    .rst     (rx_rst),
    .start   (u_start),
    .data_in (u_data),
    .data_en (u_en),
    .crc_out (u_crc)
  );

  // Synchronous frame buffer
  always @(posedge RX_CLK) rd_data <= mem[rd_addr];

  // Bit-serial reference CRC-32 (reflected, data LSB first)
  function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = v[31-b];
    return r;
  endfunction

  // Receiver side: CRC over everything after the SFD, including FCS, must leave the residue
  function automatic int residue_of_last();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    if (last_q.size() < 24) return 0;
    for (int i = 16; i + 1 < last_q.size(); i += 2) c = ref_crc(c, {last_q[i+1], last_q[i]});
    return (bitrev32(c) == CRC_RESIDUE) ? 1 : 0;
  endfunction

  // Wire monitor: collects nibbles per frame, gap lengths, done pulses, address bound
  always @(negedge RX_CLK) begin
    if (done) done_cnt++;
    if (busy && cur_len > 0 && int'(rd_addr) >= cur_len) addr_viol++;
    if (RX_DV) begin
      if (!prev_dv && frames > 0) last_gap = low_run;
      cur_q.push_back(RX_DATA);
      low_run = 0;
    end else begin
      if (prev_dv) begin
        last_q = cur_q;
        cur_q.delete();
        frames++;
        last_res = residue_of_last();
      end
      low_run++;
    end
    prev_dv = RX_DV;
  end

  task automatic tick;
    @(negedge RX_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected nibble stream for a frame of nb payload bytes taken from mem
  task automatic build_exp(input int nb);
    logic [31:0] c;
    logic [31:0] f;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 14 + nb; i++) begin
      exp_q.push_back(mem[i][3:0]);
      exp_q.push_back(mem[i][7:4]);
      c = ref_crc(c, mem[i]);
    end
    f = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(4'((f >> (4 * k)) & 32'hF));
  endtask

  task automatic cmp_frame(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < last_q.size(); i++)
      if (last_q[i] !== exp_q[i]) mism++;
    chk({tag, "_len"}, last_q.size(), exp_q.size());
    chk({tag, "_nibbles"}, mism, 0);
    chk({tag, "_residue"}, last_res, 1);
  endtask

  // From inside a frame: count remaining DV-high samples, then gap samples until busy falls
  task automatic finish_frame(output int dv_n, output int done_at, output int idle_at);
    int n;
    int k;
    n = 0;
    while (RX_DV && n < 2000) begin n++; tick; end
    k = 1;
    done_at = 0;
    while (busy && k < 200) begin
      if (done) done_at = k;
      tick;
      k++;
    end
    dv_n = n;
    idle_at = k;
    chk("frame_bound", 32'((n < 2000) && (k < 200)), 1);
  endtask

  initial begin
    int dv_n, done_at, idle_at, dc0;
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [71:0] pay;
    logic [31:0] fv;

    rx_rst = 1'b1; send = 1'b0; nbytes = '0;
    u_start = 1'b0; u_en = 1'b0; u_data = '0;
    dmac = 48'h02_0A_35_00_00_01;
    smac = 48'h00_11_22_33_44_55;
    pay  = "123456789";
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++) mem[i] = dmac[8*(5-i) +: 8];
    for (int i = 0; i < 6; i++) mem[6+i] = smac[8*(5-i) +: 8];
    mem[12] = 8'h08; mem[13] = 8'h00;
    for (int i = 0; i < 9; i++) mem[14+i] = pay[8*(8-i) +: 8];

    // Reset state
    repeat (3) tick;
    chk("rst_dv", 32'(RX_DV), 0);
    chk("rst_data", 32'(RX_DATA), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    rx_rst = 1'b0;
    tick;

    // CRC engine known vector
    u_start = 1'b1; tick; u_start = 1'b0;
    for (int i = 0; i < 9; i++) begin u_data = pay[8*(8-i) +: 8]; u_en = 1'b1; tick; end
    u_en = 1'b0; tick;
    fv = ~u_crc;
    chk("crc_unit", fv, 32'hCBF43926);
    chk("crc_unit_b0", 32'(fv[7:0]), 32'h26);

    // Frame with 9-byte payload
    cur_len = 23; nbytes = 11'd9; send = 1'b1; tick; send = 1'b0;
    chk("first_dv", 32'(RX_DV), 1);
    chk("first_nib", 32'(RX_DATA), 5);
    chk("busy_start", 32'(busy), 1);
    finish_frame(dv_n, done_at, idle_at);
    chk("f9_dv_cycles", dv_n, 70);
    build_exp(9);
    cmp_frame("f9");

    // Header-only frame, gap/done timing
    dc0 = done_cnt;
    cur_len = 14; nbytes = 11'd0; send = 1'b1; tick; send = 1'b0;
    finish_frame(dv_n, done_at, idle_at);
    chk("f0_dv_cycles", dv_n, 52);
    chk("f0_done_at", done_at, 23);
    chk("f0_idle_at", idle_at, 24);
    chk("f0_done_cnt", done_cnt - dc0, 1);
    build_exp(0);
    cmp_frame("f0");

    // Oversize request rejected
    nbytes = 11'd1501; send = 1'b1; tick; send = 1'b0;
    chk("rej_err", 32'(err), 1);
    chk("rej_busy", 32'(busy), 0);
    chk("rej_dv", 32'(RX_DV), 0);
    tick;
    chk("rej_err_pulse", 32'(err), 0);
    chk("rej_dv2", 32'(RX_DV), 0);

    // Send during DATA is ignored
    cur_len = 23; nbytes = 11'd9; send = 1'b1; tick; send = 1'b0;
    repeat (30) tick;
    nbytes = 11'd1501; send = 1'b1; tick; send = 1'b0;
    chk("ign_err", 32'(err), 0);
    finish_frame(dv_n, done_at, idle_at);
    build_exp(9);
    cmp_frame("ign");

    // Reset at payload byte 5 (buffer byte 19) low nibble: DV sample 55
    nbytes = 11'd9; send = 1'b1; tick; send = 1'b0;
    repeat (54) tick;
    chk("abort_nib", 32'(RX_DATA), 32'h6);
    dc0 = done_cnt;
    #2 rx_rst = 1'b1;
    #1;
    chk("abort_dv", 32'(RX_DV), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) tick;
    rx_rst = 1'b0;
    repeat (30) tick;
    chk("abort_no_done", done_cnt - dc0, 0);
    nbytes = 11'd9; send = 1'b1; tick; send = 1'b0;
    finish_frame(dv_n, done_at, idle_at);
    chk("post_rst_dv_cycles", dv_n, 70);
    cmp_frame("post_rst");

    // Back-to-back with send held high
    cur_len = 14; nbytes = 11'd0; send = 1'b1; tick;
    finish_frame(dv_n, done_at, idle_at);
    chk("b2b_res1", last_res, 1);
    tick;
    chk("b2b_restart", 32'(RX_DV), 1);
    chk("b2b_gap", last_gap, 24);
    send = 1'b0;
    finish_frame(dv_n, done_at, idle_at);
    chk("b2b_dv_cycles2", dv_n, 52);
    build_exp(0);
    cmp_frame("b2b2");
    repeat (5) tick;
    chk("b2b_stop", 32'(RX_DV), 0);
    chk("addr_bound", addr_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
